// File: rtl/terminal_pkg.sv
// Shared terminal definitions: screen geometry, pipeline depth, ASCII codes, payload types.
// STATUS_PIN_EN reserves one buffer row for a pinned status line and lowers the scroll limit by one.
package terminal_pkg;

   localparam int unsigned SCREEN_WIDTH   = 76;
   localparam int unsigned SCREEN_HEIGHT  = 44;
   localparam int unsigned VIEW_ROWS      = 22;
   localparam int unsigned STATUS_ROW     = 42;
   localparam int unsigned RENDER_LATENCY = 7;
   localparam int unsigned CELL_W         = 16;
   localparam int unsigned CELL_H         = 32;
   localparam int unsigned H_ACTIVE       = 1280;
   localparam int unsigned V_ACTIVE       = 720;
   localparam int unsigned BUF_DEPTH      = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam int unsigned ADDR_W         = $clog2(BUF_DEPTH);
   localparam int unsigned OFF_W          = 6;

`ifdef STATUS_PIN_EN
   localparam int unsigned SCROLL_MAX     = SCREEN_HEIGHT - VIEW_ROWS - 1;
`else
   localparam int unsigned SCROLL_MAX     = SCREEN_HEIGHT - VIEW_ROWS;
`endif

   localparam logic [7:0]  ASCII_SPACE    = 8'd32;
   localparam logic [7:0]  ASCII_NEWLINE  = 8'd10;
   localparam logic [7:0]  ASCII_TILDE    = 8'd126;

   localparam logic [23:0] FG_COLOR       = 24'h00FF00;
   localparam logic [23:0] BG_COLOR       = 24'h000000;

   typedef enum logic {CLEAR, RUN} state_t;

   // Per-pixel data carried alongside the buffer/font reads
   typedef struct packed {
      logic       in_text;
      logic [3:0] font_row;
      logic [2:0] bit_idx;
   } pix_meta_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
   } sync_t;

endpackage

// File: rtl/glyph_rom.sv
// 2048x8 glyph ROM (128 codes x 16 rows), two registered read stages.
// Contents come from the built-in generator below, standing in for font_8x16.mem.
module glyph_rom (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] addr,
   output logic [7:0]  data
);

   // Glyph table: space and the top/bottom font rows are empty, every other row gets a boxed pattern
   function automatic logic [7:0] font_bits(input logic [10:0] a);
      logic [6:0] code;
      logic [3:0] r;
      code = a[10:4];
      r    = a[3:0];
      if (code == 7'd32 || r == 4'd0 || r >= 4'd14) begin
         font_bits = 8'h00;
      end else begin
         font_bits = ({1'b0, code} ^ 8'({4'd0, r} * 8'd17)) | 8'h81;
      end
   endfunction

   logic [7:0] rom_d, rom_q, data_q;

   // ROM lookup
   always_comb begin
      rom_d = font_bits(addr);
   end

   // Address-side and output-side read registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_q  <= 8'h00;
         data_q <= 8'h00;
      end else begin
         rom_q  <= rom_d;
         data_q <= rom_q;
      end
   end

   assign data = data_q;

endmodule

// File: rtl/text_grid_renderer.sv
// Character buffer, scrolling viewport and 7-stage glyph pixel pipeline for the 720p output.
// `define STATUS_PIN_EN pins buffer row STATUS_ROW to the last visible row.
module text_grid_renderer
   import terminal_pkg::*;
(
   input  logic              pixel_clk_in,
   input  logic              rst_in,
   input  logic              tg_we,
   input  logic [ADDR_W-1:0] tg_addr,
   input  logic [7:0]        tg_input,
   input  logic              scroll_up,
   input  logic              scroll_down,
   input  logic [10:0]       hcount_in,
   input  logic [9:0]        vcount_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              active_in,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              active_out,
   output logic [7:0]        red_out,
   output logic [7:0]        green_out,
   output logic [7:0]        blue_out,
   output logic              clear_busy
);

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         clr_addr_q, clr_addr_d;
   logic                      clear_busy_q, clear_busy_d;
   logic [OFF_W-1:0]          scroll_off_q, scroll_off_d;
   logic                      pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
   logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
   pix_meta_t [4:0]           meta_q, meta_d;
   sync_t [RENDER_LATENCY-1:0] sync_q, sync_d;
   logic [1:0]                prt_q, prt_d;
   logic                      pix_q, pix_d;
   logic [23:0]               rgb_q, rgb_d;

   logic [7:0]                char_mem [BUF_DEPTH];
   logic [7:0]                char_q, char2_q;
   logic                      we_c;
   logic [ADDR_W-1:0]         wr_addr_c;
   logic [7:0]                wr_data_c;
   logic [10:0]               rom_addr_c;
   logic [7:0]                rom_data;
   logic [4:0]                vrow_c;
   logic [6:0]                col_c;
   logic [OFF_W-1:0]          buf_row_c;
   logic                      in_text_c, up_c, dn_c;

   // Clear sequencer: walk every address once after reset, then hand the buffer to the write port
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == ADDR_W'(BUF_DEPTH - 1)) begin
               state_d    = RUN;
               clr_addr_d = '0;
            end
         end
         default: ;
      endcase
      clear_busy_d = (state_d == CLEAR);
   end

   // Scroll requests latch until start of vblank; opposing requests cancel, limits saturate
   always_comb begin
      up_c         = pend_up_q | scroll_up;
      dn_c         = pend_dn_q | scroll_down;
      pend_up_d    = up_c;
      pend_dn_d    = dn_c;
      scroll_off_d = scroll_off_q;
      if (hcount_in == 11'd0 && vcount_in == 10'(V_ACTIVE)) begin
         pend_up_d = 1'b0;
         pend_dn_d = 1'b0;
         if (up_c && !dn_c && scroll_off_q != '0) begin
            scroll_off_d = scroll_off_q - OFF_W'(1);
         end else if (dn_c && !up_c && scroll_off_q < OFF_W'(SCROLL_MAX)) begin
            scroll_off_d = scroll_off_q + OFF_W'(1);
         end
      end
   end

   // Buffer write mux: clear sequencer owns the port until RUN
   always_comb begin
      we_c      = 1'b0;
      wr_addr_c = tg_addr;
      wr_data_c = tg_input;
      if (state_q == CLEAR) begin
         we_c      = 1'b1;
         wr_addr_c = clr_addr_q;
         wr_data_c = ASCII_SPACE;
      end else if (tg_we && (32'(tg_addr) < BUF_DEPTH)) begin
         we_c = 1'b1;
      end
   end

   // Buffer write port
   always_ff @(posedge pixel_clk_in) begin
      if (we_c) begin
         char_mem[wr_addr_c] <= wr_data_c;
      end
   end

   // Buffer read port (read-first against a same-edge write) and its output register
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         char_q  <= 8'h00;
         char2_q <= 8'h00;
      end else begin
         char_q  <= char_mem[rd_addr_q];
         char2_q <= char_q;
      end
   end

   // Pixel pipeline: cell address, glyph address, bit select, colour
   always_comb begin
      vrow_c    = vcount_in[9:5];
      col_c     = hcount_in[10:4];
      in_text_c = (hcount_in < 11'(SCREEN_WIDTH * CELL_W)) &&
                  (vcount_in < 10'(VIEW_ROWS * CELL_H));
      buf_row_c = OFF_W'(vrow_c) + scroll_off_q;
`ifdef STATUS_PIN_EN
      if (vrow_c == 5'(VIEW_ROWS - 1)) begin
         buf_row_c = OFF_W'(STATUS_ROW);
      end
`endif
      rd_addr_d = '0;
      if (in_text_c) begin
         rd_addr_d = ADDR_W'(32'(buf_row_c) * SCREEN_WIDTH + 32'(col_c));
      end
      meta_d     = {meta_q[3:0], pix_meta_t'{in_text_c, vcount_in[4:1], hcount_in[3:1]}};
      sync_d     = {sync_q[RENDER_LATENCY-2:0], sync_t'{hsync_in, vsync_in, active_in}};
      rom_addr_c = {char2_q[6:0], meta_q[2].font_row};
      prt_d      = {prt_q[0], (char2_q >= ASCII_SPACE) && (char2_q <= ASCII_TILDE)};
      pix_d      = meta_q[4].in_text & prt_q[1] & rom_data[3'(3'd7 - meta_q[4].bit_idx)];
      rgb_d      = 24'h000000;
      if (sync_q[RENDER_LATENCY-2].active && !clear_busy_q) begin
         rgb_d = pix_q ? FG_COLOR : BG_COLOR;
      end
   end

   // State, scroll and pipeline registers
   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= CLEAR;
         clr_addr_q   <= '0;
         clear_busy_q <= 1'b1;
         scroll_off_q <= '0;
         pend_up_q    <= 1'b0;
         pend_dn_q    <= 1'b0;
         rd_addr_q    <= '0;
         meta_q       <= '0;
         sync_q       <= '0;
         prt_q        <= '0;
         pix_q        <= 1'b0;
         rgb_q        <= 24'h000000;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         clear_busy_q <= clear_busy_d;
         scroll_off_q <= scroll_off_d;
         pend_up_q    <= pend_up_d;
         pend_dn_q    <= pend_dn_d;
         rd_addr_q    <= rd_addr_d;
         meta_q       <= meta_d;
         sync_q       <= sync_d;
         prt_q        <= prt_d;
         pix_q        <= pix_d;
         rgb_q        <= rgb_d;
      end
   end

   glyph_rom u_glyph_rom (
      .clk  (pixel_clk_in),
      .rst  (rst_in),
      .addr (rom_addr_c),
      .data (rom_data)
   );

   assign hsync_out  = sync_q[RENDER_LATENCY-1].hsync;
   assign vsync_out  = sync_q[RENDER_LATENCY-1].vsync;
   assign active_out = sync_q[RENDER_LATENCY-1].active;
   assign red_out    = rgb_q[23:16];
   assign green_out  = rgb_q[15:8];
   assign blue_out   = rgb_q[7:0];
   assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_text_grid_renderer.sv
// Scoreboard bench for text_grid_renderer: expected pixels are queued at drive time and
// compared when they leave the 7-cycle pipeline. Honours STATUS_PIN_EN in its viewport model.
module tb_text_grid_renderer;

   localparam logic [23:0] FG    = 24'h00FF00;
   localparam logic [23:0] BG    = 24'h000000;
   localparam int          DEPTH = 76 * 44;
   localparam int          LAT   = 7;
`ifdef STATUS_PIN_EN
   localparam int          OFF_MAX = 21;
`else
   localparam int          OFF_MAX = 22;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        tg_we;
   logic [11:0] tg_addr;
   logic [7:0]  tg_input;
   logic        scroll_up, scroll_down;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        hsync_in, vsync_in, active_in;
   logic        hsync_out, vsync_out, active_out;
   logic [7:0]  red_out, green_out, blue_out;
   logic        clear_busy;

   typedef struct {
      int          due;
      logic [23:0] rgb;
      logic [2:0]  syn;
      string       tag;
   } sb_t;

   sb_t sbq[$];
   int  mdl [DEPTH];
   int  off;
   int  cyc;
   int  n_total;
   int  n_bad;

   text_grid_renderer dut (
      .pixel_clk_in (clk),
      .rst_in       (rst),
      .tg_we        (tg_we),
      .tg_addr      (tg_addr),
      .tg_input     (tg_input),
      .scroll_up    (scroll_up),
      .scroll_down  (scroll_down),
      .hcount_in    (hcount_in),
      .vcount_in    (vcount_in),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .active_in    (active_in),
      .hsync_out    (hsync_out),
      .vsync_out    (vsync_out),
      .active_out   (active_out),
      .red_out      (red_out),
      .green_out    (green_out),
      .blue_out     (blue_out),
      .clear_busy   (clear_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Font table as defined for the glyph ROM; unprintable codes render blank
   function automatic logic [7:0] glyph(input int code, input int r);
      if (code <= 32 || code > 126) return 8'h00;
      if (r == 0 || r >= 14) return 8'h00;
      return 8'((code ^ (r * 17)) | 'h81);
   endfunction

   function automatic logic [23:0] exp_rgb(input int h, input int v, input bit act);
      int row;
      int code;
      logic [7:0] g;
      if (!act) return 24'h000000;
      if (h >= 76 * 16 || v >= 22 * 32) return BG;
      row = v / 32 + off;
`ifdef STATUS_PIN_EN
      if (v / 32 == 21) row = 42;
`endif
      code = mdl[row * 76 + h / 16];
      g    = glyph(code, (v % 32) / 2);
      return g[7 - (h % 16) / 2] ? FG : BG;
   endfunction

   task automatic drain();
      sb_t e;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         e = sbq.pop_front();
         check(e.tag, {8'h00, red_out, green_out, blue_out}, {8'h00, e.rgb});
         check({e.tag, "/sync"}, {29'd0, hsync_out, vsync_out, active_out}, {29'd0, e.syn});
      end
   endtask

   task automatic tick();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      hcount_in = 11'd2047;
      vcount_in = 10'd1023;
      hsync_in  = 1'b0;
      vsync_in  = 1'b0;
      active_in = 1'b0;
   endtask

   task automatic wr(input int a, input int d);
      tg_we    = 1'b1;
      tg_addr  = 12'(a);
      tg_input = 8'(d);
      tick();
      tg_we = 1'b0;
      if (a < DEPTH) mdl[a] = d;
   endtask

   // Pulse(s) then one start-of-vblank cycle; the model applies the net step
   task automatic scroll(input bit u1, input bit d1, input bit u2, input bit d2);
      bit u, d;
      scroll_up   = u1;
      scroll_down = d1;
      tick();
      scroll_up   = 1'b0;
      scroll_down = 1'b0;
      if (u2 || d2) begin
         scroll_up   = u2;
         scroll_down = d2;
         tick();
         scroll_up   = 1'b0;
         scroll_down = 1'b0;
      end
      hcount_in = 11'd0;
      vcount_in = 10'd720;
      tick();
      idle();
      tick();
      u = u1 | u2;
      d = d1 | d2;
      if (u && !d && off > 0) off--;
      else if (d && !u && off < OFF_MAX) off++;
   endtask

   // Render a pixel window; optionally issue one buffer write at pixel index wi
   task automatic render_box(input string nm, input int h0, input int h1, input int v0,
                             input int v1, input int wi, input int wa, input int wd);
      int  i;
      bit  hs, vs, act;
      sb_t e;
      i = 0;
      for (int v = v0; v < v1; v++) begin
         for (int h = h0; h < h1; h++) begin
            if (i == wi) begin
               tg_we    = 1'b1;
               tg_addr  = 12'(wa);
               tg_input = 8'(wd);
               mdl[wa]  = wd;
            end else begin
               tg_we = 1'b0;
            end
            hs  = 1'($urandom);
            vs  = 1'($urandom);
            act = ($urandom_range(0, 7) != 0);
            hcount_in = 11'(h);
            vcount_in = 10'(v);
            hsync_in  = hs;
            vsync_in  = vs;
            active_in = act;
            e.due = cyc + LAT;
            e.rgb = exp_rgb(h, v, act);
            e.syn = {hs, vs, act};
            e.tag = $sformatf("%s h%0d v%0d", nm, h, v);
            sbq.push_back(e);
            tick();
            i++;
         end
      end
      tg_we = 1'b0;
      idle();
   endtask

   initial begin
      int n;
      n_total     = 0;
      n_bad       = 0;
      cyc         = 0;
      off         = 0;
      rst         = 1'b1;
      tg_we       = 1'b0;
      tg_addr     = 12'd0;
      tg_input    = 8'd0;
      scroll_up   = 1'b0;
      scroll_down = 1'b0;
      idle();
      hsync_in    = 1'b1;
      vsync_in    = 1'b1;
      active_in   = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) tick();

      // Reset state
      check("rst_rgb", {8'h00, red_out, green_out, blue_out}, 32'd0);
      check("rst_sync", {29'd0, hsync_out, vsync_out, active_out}, 32'd0);
      check("rst_busy", {31'd0, clear_busy}, 32'd1);
      idle();

      // Partial clear, then reset again mid-clear
      rst = 1'b0;
      repeat (1000) tick();
      check("busy_midclear", {31'd0, clear_busy}, 32'd1);
      rst = 1'b1;
      repeat (2) tick();
      check("rst2_busy", {31'd0, clear_busy}, 32'd1);
      rst = 1'b0;

      // Restarted clear must take the full buffer length; a write during it is dropped
      n = 0;
      for (int i = 0; i < 5000; i++) begin
         tg_we = (i == 200);
         tg_addr  = 12'd3;
         tg_input = 8'd90;
         @(negedge clk);
         if (!clear_busy) break;
         n++;
         @(posedge clk);
         #1;
         cyc++;
      end
      tg_we = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      check("clear_cycles", 32'(n), 32'd3344);
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32;

      // Cleared screen renders background, including text-area edges
      render_box("blank", 0, 80, 0, 32, -1, 0, 0);
      render_box("edge", 1200, 1232, 700, 708, -1, 0, 0);
      render_box("outside", 1276, 1284, 716, 724, -1, 0, 0);

      // Glyphs, unprintables and an out-of-range write
      wr(0, 65);
      wr(5, 10);
      wr(6, 200);
      wr(7, 126);
      wr(75, 87);
      wr(3344, 81);
      render_box("cells", 0, 128, 0, 32, -1, 0, 0);
      render_box("col75", 1184, 1232, 0, 32, -1, 0, 0);

      // Same-edge write and read of cell 1: the earlier pixel still sees the old char
      render_box("rdfirst", 16, 32, 4, 6, 13, 1, 66);
      render_box("cell1", 16, 32, 0, 32, -1, 0, 0);

      // Scrolling
      wr(5 * 76 + 2, 77);
      wr(30 * 76, 120);
      wr(42 * 76 + 1, 33);
      repeat (3) scroll(1'b1, 1'b0, 1'b0, 1'b0);
      render_box("up_sat", 0, 48, 0, 32, -1, 0, 0);
      render_box("last_row0", 16, 32, 672, 704, -1, 0, 0);
      scroll(1'b0, 1'b1, 1'b0, 1'b1);
      repeat (4) scroll(1'b0, 1'b1, 1'b0, 1'b0);
      render_box("off5", 32, 48, 0, 32, -1, 0, 0);
      scroll(1'b1, 1'b1, 1'b0, 1'b0);
      scroll(1'b1, 1'b0, 1'b0, 1'b1);
      render_box("cancel", 32, 48, 0, 32, -1, 0, 0);
      repeat (4) scroll(1'b0, 1'b1, 1'b0, 1'b0);
      render_box("off9_r21", 0, 16, 672, 704, -1, 0, 0);
      render_box("off9_r20", 0, 16, 640, 672, -1, 0, 0);
      repeat (20) scroll(1'b0, 1'b1, 1'b0, 1'b0);
      render_box("dn_sat", 0, 16, 256, 320, -1, 0, 0);
      render_box("last_rowmax", 16, 32, 672, 704, -1, 0, 0);
      repeat (30) scroll(1'b1, 1'b0, 1'b0, 1'b0);
      render_box("back0", 0, 16, 0, 32, -1, 0, 0);
      render_box("last_rowback", 16, 32, 672, 704, -1, 0, 0);

      repeat (LAT + 3) tick();
      check("sb_empty", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
